iter_mul_div_unit: RTL

//  Iterative multiply/divide unit with HI/LO result registers for the pipelined
//  CPU. The EXE stage launches MULT/MULTU/DIV/DIVU/MTHI/MTLO here. The unit then

---
 rtl/iter_mul_div_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/iter_mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Latency: MUL/DIV take N+1 busy cycles (N = WIDTH/MUL_BITS for multiply, WIDTH for divide); MTHI/MTLO take one edge.
// Backpressure: none internal; a start that arrives while busy is ignored, so the pipeline stalls MDU users while busy.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   i_MDU_start/op      launch strobe and opcode (0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6-7 NOP)
//   i_MDU_a/b           rs/rt operands
//   i_MDU_flush         abort any in-flight op; also drops a start in the same cycle
//   o_MDU_busy/done     op in flight / one-cycle pulse when HI/LO were written by MUL/DIV
//   o_MDU_hi/lo         committed HI/LO
module iter_mul_div_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_MDU_start,
    input  logic [2:0]       i_MDU_op,
    input  logic [WIDTH-1:0] i_MDU_a,
    input  logic [WIDTH-1:0] i_MDU_b,
    input  logic             i_MDU_flush,
    output logic             o_MDU_busy,
    output logic             o_MDU_done,
    output logic [WIDTH-1:0] o_MDU_hi,
    output logic [WIDTH-1:0] o_MDU_lo
);
    localparam int W     = WIDTH;
    localparam int MB    = MUL_BITS;
    localparam int N_MUL = W / MB;
    localparam int CW    = $clog2(W + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state;
    logic            is_div;
    logic            neg_res;   // negate product / quotient in FIX
    logic            neg_rem;   // negate remainder in FIX (dividend was negative)
    logic [W-1:0]    opnd;      // multiplicand magnitude, or divisor magnitude
    logic [2*W-1:0]  acc;       // mul: {partial hi, remaining multiplier}; div: {remainder, quotient/dividend}
    logic [CW-1:0]   cnt;

    // Operand decode in IDLE
    logic         signed_op;
    logic         a_neg, b_neg, b_zero;
    logic [W-1:0] a_mag, b_mag;

    // Multiply step: add opnd * low MB multiplier bits to the upper half, shift right by MB
    logic [W+MB-1:0] partial, msum;
    logic [2*W-1:0]  acc_mul;

    // Restoring divide step: shift one dividend bit into the remainder, subtract if it fits
    logic            div_ge;
    logic [W-1:0]    div_sub;
    logic [2*W-1:0]  acc_div;

    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix, rem_fix;

    always_comb begin
        signed_op = (i_MDU_op == OP_MULT) || (i_MDU_op == OP_DIV);
        a_neg     = signed_op & i_MDU_a[W-1];
        b_neg     = signed_op & i_MDU_b[W-1];
        b_zero    = (i_MDU_b == '0);
        a_mag     = a_neg ? -i_MDU_a : i_MDU_a;
        b_mag     = b_neg ? -i_MDU_b : i_MDU_b;

        partial   = {{MB{1'b0}}, opnd} * {{W{1'b0}}, acc[MB-1:0]};
        msum      = {{MB{1'b0}}, acc[2*W-1:W]} + partial;
        acc_mul   = {msum, acc[W-1:MB]};

        // The shifted remainder is W+1 bits; when it fits, the difference is below
        // the divisor, so W-bit modular subtraction gives the exact new remainder.
        div_ge    = {acc[2*W-1:W], acc[W-1]} >= {1'b0, opnd};
        div_sub   = {acc[2*W-2:W], acc[W-1]} - opnd;
        acc_div   = div_ge ? {div_sub, acc[W-2:0], 1'b1} : {acc[2*W-2:0], 1'b0};

        prod_fix  = neg_res ? -acc : acc;
        quo_fix   = neg_res ? -acc[W-1:0] : acc[W-1:0];
        rem_fix   = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            is_div     <= 1'b0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            opnd       <= '0;
            acc        <= '0;
            cnt        <= '0;
            o_MDU_busy <= 1'b0;
            o_MDU_done <= 1'b0;
            o_MDU_hi   <= '0;
            o_MDU_lo   <= '0;
        end else begin
            o_MDU_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_MDU_start && !i_MDU_flush) begin
                        case (i_MDU_op)
                            OP_MULT, OP_MULTU: begin
                                is_div     <= 1'b0;
                                neg_res    <= a_neg ^ b_neg;
                                neg_rem    <= 1'b0;
                                opnd       <= a_mag;
                                acc        <= {{W{1'b0}}, b_mag};
                                cnt        <= CW'(N_MUL);
                                state      <= RUN;
                                o_MDU_busy <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                // Divide by zero: quotient stays all-ones and the
                                // remainder comes back as the original dividend.
                                is_div     <= 1'b1;
                                neg_res    <= (a_neg ^ b_neg) & ~b_zero;
                                neg_rem    <= a_neg;
                                opnd       <= b_mag;
                                acc        <= {{W{1'b0}}, a_mag};
                                cnt        <= CW'(W);
                                state      <= RUN;
                                o_MDU_busy <= 1'b1;
                            end
                            OP_MTHI: o_MDU_hi <= i_MDU_a;
                            OP_MTLO: o_MDU_lo <= i_MDU_a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (i_MDU_flush) begin
                        state      <= IDLE;
                        o_MDU_busy <= 1'b0;
                    end else begin
                        acc <= is_div ? acc_div : acc_mul;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    state      <= IDLE;
                    o_MDU_busy <= 1'b0;
                    // A squash landing on the commit cycle discards the result.
                    if (!i_MDU_flush) begin
                        o_MDU_done <= 1'b1;
                        if (is_div) begin
                            o_MDU_hi <= rem_fix;
                            o_MDU_lo <= quo_fix;
                        end else begin
                            o_MDU_hi <= prod_fix[2*W-1:W];
                            o_MDU_lo <= prod_fix[W-1:0];
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    o_MDU_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
